// File: rtl/matrix_rx.sv
`timescale 1ns/1ps
// Far-end receiver of the LED-matrix serial link: shifts in one 16-bit command
// word per cascaded driver while cs is low and commits them on the rising edge of cs.
module matrix_rx #(
    parameter int unsigned NDEV = 8
) (
    input  logic                       clk_9m,
    input  logic                       rst,
    input  logic                       cs,
    input  logic                       din,
    output logic [7:0][8*NDEV-1:0]     row,
    output logic [4*NDEV-1:0]          intensity,
    output logic [NDEV-1:0]            shutdown_n,
    output logic [NDEV-1:0]            test,
    output logic                       frame_done,
    output logic                       frame_err
);

    localparam int unsigned SR_W  = 16 * NDEV;
    localparam int unsigned CNT_W = $clog2(SR_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SR_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SR_W + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [1:0]              state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [SR_W-1:0]         sr, sr_nxt;
    logic                    cs_q;
    logic [7:0][8*NDEV-1:0]  row_nxt;
    logic [4*NDEV-1:0]       intensity_nxt;
    logic [NDEV-1:0]         shutdown_n_nxt;
    logic [NDEV-1:0]         test_nxt;
    logic                    frame_done_nxt;
    logic                    frame_err_nxt;
    logic [3:0]              addr;
    logic [7:0]              data;

    // The top don't-care bit of the first word is shifted out and never decoded.
    logic unused_sr_msb;
    assign unused_sr_msb = sr[SR_W-1];

    // Next-state, shift register, counter and register-file update.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        sr_nxt         = sr;
        row_nxt        = row;
        intensity_nxt  = intensity;
        shutdown_n_nxt = shutdown_n;
        test_nxt       = test;
        frame_done_nxt = 1'b0;
        frame_err_nxt  = 1'b0;
        addr           = 4'h0;
        data           = 8'h00;

        case (state)
            ST_IDLE: begin
                if (cs_q && !cs) begin
                    state_nxt = ST_SHIFT;
                    sr_nxt    = {sr[SR_W-2:0], din};
                    cnt_nxt   = CNT_W'(1);
                end
            end

            ST_SHIFT: begin
                if (cs) begin
                    state_nxt = ST_COMMIT;
                end else begin
                    sr_nxt = {sr[SR_W-2:0], din};
                    // Saturate so an overlong frame can never alias to a full one.
                    if (cnt != CNT_SAT) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end

            ST_COMMIT: begin
                if (cnt == CNT_FULL) begin
                    frame_done_nxt = 1'b1;
                    for (int unsigned d = 0; d < NDEV; d++) begin
                        addr = sr[16*d+8 +: 4];
                        data = sr[16*d +: 8];
                        for (int unsigned r = 0; r < 8; r++) begin
                            if (addr == 4'(r + 1)) begin
                                row_nxt[r][8*d +: 8] = data;
                            end
                        end
                        case (addr)
                            4'hA:    intensity_nxt[4*d +: 4] = data[3:0];
                            4'hC:    shutdown_n_nxt[d]       = data[0];
                            4'hF:    test_nxt[d]             = data[0];
                            default: ;
                        endcase
                    end
                end else begin
                    frame_err_nxt = 1'b1;
                end

                // A low cs during commit is already bit 0 of the next frame.
                if (!cs) begin
                    state_nxt = ST_SHIFT;
                    sr_nxt    = {sr[SR_W-2:0], din};
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_9m or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sr         <= '0;
            cs_q       <= 1'b1;
            row        <= '0;
            intensity  <= '0;
            shutdown_n <= '0;
            test       <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sr         <= sr_nxt;
            cs_q       <= cs;
            row        <= row_nxt;
            intensity  <= intensity_nxt;
            shutdown_n <= shutdown_n_nxt;
            test       <= test_nxt;
            frame_done <= frame_done_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

endmodule

// File: tb/tb_matrix_rx.sv
`timescale 1ns/1ps
// Directed bench for matrix_rx: frames are driven serially, expected register
// state is queued per frame and compared when the commit pulse appears.
module tb_matrix_rx;

    localparam int unsigned NDEV = 8;

    typedef struct {
        logic            done;
        logic            err;
        logic [7:0][63:0] row;
        logic [31:0]     inten;
        logic [7:0]      shd;
        logic [7:0]      tst;
    } exp_t;

    logic             clk_9m;
    logic             rst;
    logic             cs;
    logic             din;
    logic [7:0][63:0] row;
    logic [31:0]      intensity;
    logic [7:0]       shutdown_n;
    logic [7:0]       test;
    logic             frame_done;
    logic             frame_err;

    matrix_rx #(.NDEV(NDEV)) dut (
        .clk_9m     (clk_9m),
        .rst        (rst),
        .cs         (cs),
        .din        (din),
        .row        (row),
        .intensity  (intensity),
        .shutdown_n (shutdown_n),
        .test       (test),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    initial clk_9m = 1'b0;
    always #5 clk_9m = ~clk_9m;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int last_done = 0;
    int prev_done = 0;
    int last_pulse = 0;

    exp_t sb[$];
    exp_t mon_e;

    logic [7:0][63:0] m_row;
    logic [31:0]      m_int;
    logic [7:0]       m_shd;
    logic [7:0]       m_tst;
    logic [15:0]      wbuf [8];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Pulse monitor: pops the scoreboard and compares the committed state.
    always @(posedge clk_9m) begin
        cyc++;
        #1;
        if (frame_done || frame_err) begin
            last_pulse = cyc;
            chk("pulse_exclusive", 512'(frame_done & frame_err), 512'(0));
            if (frame_done) begin
                done_cnt++;
                prev_done = last_done;
                last_done = cyc;
            end
            if (frame_err) err_cnt++;
            n_checks++;
            assert (sb.size() != 0) else begin
                n_errors++;
                $error("FAIL unexpected_pulse observed=%0d expected=%0d", frame_done, 0);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("sb_done", 512'(frame_done), 512'(mon_e.done));
                chk("sb_err", 512'(frame_err), 512'(mon_e.err));
                chk("sb_row", 512'(row), 512'(mon_e.row));
                chk("sb_intensity", 512'(intensity), 512'(mon_e.inten));
                chk("sb_shutdown", 512'(shutdown_n), 512'(mon_e.shd));
                chk("sb_test", 512'(test), 512'(mon_e.tst));
            end
        end
    end

    task automatic fill(input logic [15:0] v);
        for (int d = 0; d < 8; d++) wbuf[d] = v;
    endtask

    // Reference behaviour of one committed (or rejected) frame.
    task automatic expect_frame(input int nbits);
        exp_t e;
        if (nbits == 128) begin
            for (int d = 0; d < 8; d++) begin
                case (wbuf[d][11:8])
                    4'h1: m_row[0][8*d +: 8] = wbuf[d][7:0];
                    4'h2: m_row[1][8*d +: 8] = wbuf[d][7:0];
                    4'h3: m_row[2][8*d +: 8] = wbuf[d][7:0];
                    4'h4: m_row[3][8*d +: 8] = wbuf[d][7:0];
                    4'h5: m_row[4][8*d +: 8] = wbuf[d][7:0];
                    4'h6: m_row[5][8*d +: 8] = wbuf[d][7:0];
                    4'h7: m_row[6][8*d +: 8] = wbuf[d][7:0];
                    4'h8: m_row[7][8*d +: 8] = wbuf[d][7:0];
                    4'hA: m_int[4*d +: 4] = wbuf[d][3:0];
                    4'hC: m_shd[d] = wbuf[d][0];
                    4'hF: m_tst[d] = wbuf[d][0];
                    default: ;
                endcase
            end
        end
        e.done  = (nbits == 128);
        e.err   = (nbits != 128);
        e.row   = m_row;
        e.inten = m_int;
        e.shd   = m_shd;
        e.tst   = m_tst;
        sb.push_back(e);
    endtask

    // Drives nbits of the stream, first word = device 7, MSB first; extra bits are 1.
    task automatic send_bits(input int nbits);
        for (int k = 0; k < nbits; k++) begin
            logic b;
            int   dev;
            int   bt;
            dev = 7 - k / 16;
            bt  = 15 - k % 16;
            if (k < 128) b = wbuf[3'(dev)][4'(bt)];
            else         b = 1'b1;
            @(negedge clk_9m);
            cs  = 1'b0;
            din = b;
        end
    endtask

    task automatic end_frame();
        @(negedge clk_9m);
        cs  = 1'b1;
        din = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (4) @(negedge clk_9m);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk_9m);
        chk(tag, 512'(sb.size()), 512'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cs_high_cyc;
        int d0;
        int e0;
        rst = 1'b0;
        cs  = 1'b1;
        din = 1'b0;
        m_row = '0; m_int = '0; m_shd = '0; m_tst = '0;
        repeat (3) @(negedge clk_9m);
        chk("reset_row", 512'(row), 512'(0));
        chk("reset_misc", 512'({intensity, shutdown_n, test, frame_done, frame_err}), 512'(0));
        rst = 1'b1;
        repeat (2) @(negedge clk_9m);

        // Valid digit-0 write on every device
        fill(16'h01A5);
        expect_frame(128);
        send_bits(128);
        end_frame();
        cs_high_cyc = cyc;
        drain("t1_drain");
        chk("t1_latency", 512'(last_pulse - cs_high_cyc), 512'(2));
        chk("t1_row0", 512'(row[0]), 512'(64'hA5A5_A5A5_A5A5_A5A5));
        chk("t1_row1", 512'(row[1]), 512'(0));
        chk("t1_counts", 512'({done_cnt, err_cnt}), 512'({32'd1, 32'd0}));

        // Mixed addresses across devices
        fill(16'h0000);
        wbuf[7] = 16'h0A0F;
        wbuf[1] = 16'h0C01;
        wbuf[0] = 16'h0833;
        expect_frame(128);
        send_bits(128);
        end_frame();
        drain("t2_drain");
        chk("t2_intensity", 512'(intensity), 512'(32'hF000_0000));
        chk("t2_shutdown", 512'(shutdown_n), 512'(8'b0000_0010));
        chk("t2_row7", 512'(row[7]), 512'(64'h33));
        chk("t2_row0_kept", 512'(row[0]), 512'(64'hA5A5_A5A5_A5A5_A5A5));

        // Short frame (127 bits) is rejected
        fill(16'h01FF);
        expect_frame(127);
        send_bits(127);
        end_frame();
        drain("t3_drain");
        chk("t3_row0_kept", 512'(row[0]), 512'(64'hA5A5_A5A5_A5A5_A5A5));
        chk("t3_err_cnt", 512'(err_cnt), 512'(1));

        // Long frame (129 bits) is rejected
        expect_frame(129);
        send_bits(129);
        end_frame();
        drain("t4_drain");
        chk("t4_row0_kept", 512'(row[0]), 512'(64'hA5A5_A5A5_A5A5_A5A5));
        chk("t4_err_cnt", 512'(err_cnt), 512'(2));

        // Back-to-back frames with a single cs-high cycle
        fill(16'h0211);
        expect_frame(128);
        send_bits(128);
        end_frame();
        fill(16'h0322);
        expect_frame(128);
        send_bits(128);
        end_frame();
        drain("t5_drain");
        chk("t5_row1", 512'(row[1]), 512'(64'h1111_1111_1111_1111));
        chk("t5_row2", 512'(row[2]), 512'(64'h2222_2222_2222_2222));
        chk("t5_spacing", 512'(last_done - prev_done), 512'(129));
        chk("t5_done_cnt", 512'(done_cnt), 512'(4));

        // Reset in the middle of a frame
        fill(16'h0401);
        send_bits(60);
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clk_9m);
        rst = 1'b0;
        cs  = 1'b1;
        din = 1'b0;
        repeat (3) @(negedge clk_9m);
        chk("t6_reset_row", 512'(row), 512'(0));
        chk("t6_reset_misc", 512'({intensity, shutdown_n, test}), 512'(0));
        m_row = '0; m_int = '0; m_shd = '0; m_tst = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk_9m);
        chk("t6_no_pulse", 512'({done_cnt, err_cnt}), 512'({d0, e0}));
        expect_frame(128);
        send_bits(128);
        end_frame();
        drain("t6_drain");
        chk("t6_row3", 512'(row[3]), 512'(64'h0101_0101_0101_0101));
        chk("t6_row0", 512'(row[0]), 512'(0));
        chk("t6_one_done", 512'(done_cnt - d0), 512'(1));
        chk("final_counts", 512'({done_cnt, err_cnt}), 512'({32'd5, 32'd2}));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
